// File: rtl/ab_stream_pkg.sv
// Shared types and defaults for the A/B pair stream serializer.
package ab_stream_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/ab_hold_buffer.sv
// One-entry skid buffer for an A/B word offered while another word is shifting.
module ab_hold_buffer
  import ab_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  output logic             full,
  output logic [WIDTH-1:0] hold_a,
  output logic [WIDTH-1:0] hold_b
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] hold_a_q, hold_a_d;
  logic [WIDTH-1:0] hold_b_q, hold_b_d;

  // A load into a full buffer is ignored so the held word can never be overwritten.
  always_comb begin
    full_d   = full_q;
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    if (take) begin
      full_d = 1'b0;
    end
    if (load && !full_q) begin
      full_d   = 1'b1;
      hold_a_d = load_a;
      hold_b_d = load_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= 1'b0;
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else begin
      full_q   <= full_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
    end
  end

  assign full   = full_q;
  assign hold_a = hold_a_q;
  assign hold_b = hold_b_q;

endmodule

// File: rtl/ab_stream_serializer.sv
// Serializes parallel A/B words into a registered bit-pair stream with zero-gap reloads.
//   state | meaning
//   IDLE  | no word on A/B, idle pair driven, next accepted word loads directly
//   SHIFT | one pair per cycle, count gives index of the pair currently on A/B
module ab_stream_serializer
  import ab_stream_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter logic MSB_FIRST = 1'b1,
  parameter logic IDLE_A    = 1'b0,
  parameter logic IDLE_B    = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             A,
  output logic             B,
  output logic             frame_start,
  output logic             busy
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             fs_q, fs_d;
  logic             busy_q, busy_d;

  logic             hold_full, hold_load, hold_take;
  logic [WIDTH-1:0] hold_a, hold_b;
  logic             accept, last, load_word;
  logic [WIDTH-1:0] word_a, word_b;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign in_ready = clr & ~hold_full;
  assign accept   = in_valid & in_ready;
  assign last     = (count_q == LAST);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    a_d       = a_q;
    b_d       = b_q;
    fs_d      = 1'b0;
    busy_d    = busy_q;
    hold_load = 1'b0;
    hold_take = 1'b0;
    load_word = 1'b0;
    word_a    = in_a;
    word_b    = in_b;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load_word = 1'b1;
        end
      end
      SHIFT: begin
        if (last) begin
          // Held word has priority; otherwise a word offered now bypasses the buffer.
          if (hold_full) begin
            load_word = 1'b1;
            word_a    = hold_a;
            word_b    = hold_b;
            hold_take = 1'b1;
          end else if (accept) begin
            load_word = 1'b1;
          end else begin
            state_d = IDLE;
            count_d = '0;
            a_d     = IDLE_A;
            b_d     = IDLE_B;
            busy_d  = 1'b0;
          end
        end else begin
          hold_load = accept;
          count_d   = count_q + CW'(1);
          a_d       = first_bit(sh_a_q);
          b_d       = first_bit(sh_b_q);
          sh_a_d    = shift_once(sh_a_q);
          sh_b_d    = shift_once(sh_b_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // The first pair goes straight to the output flops; the register keeps the rest.
    if (load_word) begin
      state_d = SHIFT;
      count_d = '0;
      a_d     = first_bit(word_a);
      b_d     = first_bit(word_b);
      sh_a_d  = shift_once(word_a);
      sh_b_d  = shift_once(word_b);
      fs_d    = 1'b1;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      count_q <= '0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      a_q     <= IDLE_A;
      b_q     <= IDLE_B;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
    end
  end

  ab_hold_buffer #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk    (clk),
    .rst_n  (clr),
    .load   (hold_load),
    .take   (hold_take),
    .load_a (in_a),
    .load_b (in_b),
    .full   (hold_full),
    .hold_a (hold_a),
    .hold_b (hold_b)
  );

  assign A           = a_q;
  assign B           = b_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ab_stream_serializer.sv
// Scoreboard bench: expected pairs are queued at each accepted word and popped per output cycle.
module tb_ab_stream_serializer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;

  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, A, B, frame_start, busy;

  logic         l_valid = 1'b0;
  logic [W-1:0] l_a = '0, l_b = '0;
  logic         l_ready, l_A, l_B, l_fs, l_busy;

  logic         i_valid = 1'b0;
  logic [W-1:0] i_a = '0, i_b = '0;
  logic         i_ready, i_A, i_B, i_fs, i_busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic a;
    logic b;
    logic fs;
  } pair_t;

  pair_t exp_q[$];

  always #5 clk = ~clk;

  ab_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_A(1'b0), .IDLE_B(1'b0)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .A(A), .B(B), .frame_start(frame_start), .busy(busy)
  );

  ab_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_A(1'b0), .IDLE_B(1'b0)) dut_lsb (
    .clk(clk), .clr(clr), .in_valid(l_valid), .in_ready(l_ready), .in_a(l_a), .in_b(l_b),
    .A(l_A), .B(l_B), .frame_start(l_fs), .busy(l_busy)
  );

  ab_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_A(1'b1), .IDLE_B(1'b0)) dut_idle (
    .clk(clk), .clr(clr), .in_valid(i_valid), .in_ready(i_ready), .in_a(i_a), .in_b(i_b),
    .A(i_A), .B(i_B), .frame_start(i_fs), .busy(i_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] a, input logic [W-1:0] b);
    pair_t p;
    for (int k = 0; k < W; k++) begin
      int idx;
      idx  = W - 1 - k;
      p.a  = a[idx];
      p.b  = b[idx];
      p.fs = (k == 0);
      exp_q.push_back(p);
    end
  endtask

  // Model of acceptance: hold buffer is full exactly when a whole word is queued behind the current pair.
  always @(posedge clk) begin
    if (clr && in_valid && (exp_q.size() < W)) push_word(in_a, in_b);
  end

  always @(negedge clk) begin
    pair_t p;
    if (!clr) begin
      exp_q.delete();
      chk("rst_A", 32'(A), 32'(0));
      chk("rst_B", 32'(B), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_fs", 32'(frame_start), 32'(0));
      chk("rst_ready", 32'(in_ready), 32'(0));
    end else begin
      chk("busy", 32'(busy), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        chk("A", 32'(A), 32'(p.a));
        chk("B", 32'(B), 32'(p.b));
        chk("frame_start", 32'(frame_start), 32'(p.fs));
      end else begin
        chk("idle_A", 32'(A), 32'(0));
        chk("idle_B", 32'(B), 32'(0));
        chk("idle_fs", 32'(frame_start), 32'(0));
      end
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < W));
    end
  end

  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b);
    logic r;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      done = r;
    end
    if (!done) chk("send_timeout", 32'(0), 32'(1));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] la_exp, lb_exp;
    #1 clr = 1'b0;
    #1;
    chk("rst_idleA", 32'(i_A), 32'(1));
    chk("rst_idleB", 32'(i_B), 32'(0));
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;

    send_word(4'b0111, 4'b1110);
    idle_cycles(6);

    la_exp  = 4'b0001;
    lb_exp  = 4'b1000;
    l_a     = 4'b0001;
    l_b     = 4'b1000;
    l_valid = 1'b1;
    @(posedge clk);
    #1 l_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("lsb_A", 32'(l_A), 32'(la_exp[k]));
      chk("lsb_B", 32'(l_B), 32'(lb_exp[k]));
      chk("lsb_fs", 32'(l_fs), 32'(k == 0));
      chk("lsb_busy", 32'(l_busy), 32'(1));
    end
    @(negedge clk);
    chk("lsb_end_busy", 32'(l_busy), 32'(0));
    chk("lsb_end_A", 32'(l_A), 32'(0));
    @(posedge clk);
    #1;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle1_A", 32'(i_A), 32'(1));
      chk("idle1_B", 32'(i_B), 32'(0));
      chk("idle1_fs", 32'(i_fs), 32'(0));
      chk("idle1_busy", 32'(i_busy), 32'(0));
    end
    @(posedge clk);
    #1;

    send_word(4'hA, 4'h3);
    send_word(4'h5, 4'hC);
    send_word(4'hF, 4'h0);
    idle_cycles(12);

    send_word(4'h9, 4'h6);
    repeat (3) @(posedge clk);
    #1;
    send_word(4'h2, 4'hD);
    idle_cycles(8);

    for (int n = 0; n < 30; n++) begin
      send_word(W'($urandom), W'($urandom));
      idle_cycles(int'($urandom_range(0, 5)));
    end
    idle_cycles(12);

    send_word(4'hB, 4'h4);
    send_word(4'h7, 4'h8);
    @(posedge clk);
    #3 clr = 1'b0;
    #1;
    chk("async_A", 32'(A), 32'(0));
    chk("async_B", 32'(B), 32'(0));
    chk("async_busy", 32'(busy), 32'(0));
    chk("async_fs", 32'(frame_start), 32'(0));
    chk("async_ready", 32'(in_ready), 32'(0));
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    send_word(4'h1, 4'hE);
    idle_cycles(2);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    idle_cycles(2);
    chk("drain", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
